// File: rtl/gpio_irq_pkg.sv
// rtl/gpio_irq_pkg.sv - register offsets, field widths and byte-lane helpers for gpio_irq_ctrl
package gpio_irq_pkg;

  localparam int DFILT_W  = 8;
  localparam int REFDIV_W = 16;

  localparam logic [11:0] OFF_DFILT    = 12'h000;
  localparam logic [11:0] OFF_REFDIV   = 12'h004;
  localparam logic [11:0] OFF_IN       = 12'h010;
  localparam logic [11:0] OFF_OUT      = 12'h020;
  localparam logic [11:0] OFF_OUT_SET  = 12'h024;
  localparam logic [11:0] OFF_OUT_CLR  = 12'h028;
  localparam logic [11:0] OFF_IRQ_EN   = 12'h030;
  localparam logic [11:0] OFF_RISE_EN  = 12'h034;
  localparam logic [11:0] OFF_FALL_EN  = 12'h038;
  localparam logic [11:0] OFF_IRQ_STAT = 12'h040;

  function automatic logic [31:0] lane_mask(input logic [3:0] we);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{we[i]}};
    return m;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [31:0] m);
    return (old & ~m) | (wd & m);
  endfunction

endpackage

// File: rtl/gpio_dfilter.sv
// rtl/gpio_dfilter.sv - one input pin: 2-flop synchroniser, tick-paced glitch filter, filtered flop
module gpio_dfilter
  import gpio_irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pin_i,
  input  logic               tick_i,
  input  logic [DFILT_W-1:0] dfilt_i,
  output logic               filt_o
);

  logic               sync1_q, sync2_q;
  logic               filt_q, filt_d;
  logic [DFILT_W-1:0] cnt_q, cnt_d;
  logic [DFILT_W:0]   cnt_inc;

  // One bit wider so the threshold compare cannot wrap at 255.
  assign cnt_inc = {1'b0, cnt_q} + (DFILT_W+1)'(1);

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (dfilt_i == '0) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else if (tick_i) begin
      if (sync2_q == filt_q) begin
        cnt_d = '0;
      end else if (cnt_inc >= {1'b0, dfilt_i}) begin
        filt_d = sync2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_inc[DFILT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// rtl/gpio_irq_ctrl.sv - GPIO controller: bus registers, prescaler, filtered inputs, edge status and irq
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter int NIN  = 13,
  parameter int NOUT = 8,
  parameter int AW   = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sel,
  input  logic [AW-1:0]   addr,
  input  logic [3:0]      we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [NIN-1:0]  gpio_pin_in,
  output logic [NOUT-1:0] gpio_pin_out,
  output logic            irq
);

  logic [DFILT_W-1:0]  dfilt_q, dfilt_d;
  logic [REFDIV_W-1:0] refdiv_q, refdiv_d;
  logic [REFDIV_W-1:0] presc_q, presc_d;
  logic [NOUT-1:0]     out_q, out_d;
  logic [NIN-1:0]      irq_en_q, irq_en_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [NIN-1:0]      stat_q, stat_d, filt, filt_d_q, w1c, edge_set;
  logic                irq_q, irq_d, tick, wr;
  logic [AW-1:0]       waddr;
  logic [31:0]         wmask;
  logic                unused_addr;

  assign unused_addr = ^addr[1:0];
  assign waddr       = {addr[AW-1:2], 2'b00};
  assign wr          = sel && (we != 4'b0000);
  assign wmask       = lane_mask(we);
  assign tick        = (presc_q == refdiv_q);

  for (genvar g = 0; g < NIN; g++) begin : g_pin
    gpio_dfilter u_dfilter (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin_i   (gpio_pin_in[g]),
      .tick_i  (tick),
      .dfilt_i (dfilt_q),
      .filt_o  (filt[g])
    );
  end

  // A fresh edge in the same cycle as a W1C leaves the bit set.
  assign edge_set = (filt & ~filt_d_q & rise_en_q) | (~filt & filt_d_q & fall_en_q);
  assign w1c      = (wr && waddr == AW'(OFF_IRQ_STAT)) ? NIN'(wdata & wmask) : '0;

  always_comb begin
    dfilt_d   = dfilt_q;
    refdiv_d  = refdiv_q;
    out_d     = out_q;
    irq_en_d  = irq_en_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    stat_d    = (stat_q & ~w1c) | edge_set;
    irq_d     = |(stat_q & irq_en_q);
    presc_d   = tick ? '0 : presc_q + REFDIV_W'(1);
    if (wr) begin
      if (waddr == AW'(OFF_DFILT)) begin
        dfilt_d = DFILT_W'(merge_lanes(32'(dfilt_q), wdata, wmask));
      end else if (waddr == AW'(OFF_REFDIV)) begin
        refdiv_d = REFDIV_W'(merge_lanes(32'(refdiv_q), wdata, wmask));
        presc_d  = '0;
      end else if (waddr == AW'(OFF_OUT)) begin
        out_d = NOUT'(merge_lanes(32'(out_q), wdata, wmask));
      end else if (waddr == AW'(OFF_OUT_SET)) begin
        out_d = out_q | NOUT'(wdata & wmask);
      end else if (waddr == AW'(OFF_OUT_CLR)) begin
        out_d = out_q & ~NOUT'(wdata & wmask);
      end else if (waddr == AW'(OFF_IRQ_EN)) begin
        irq_en_d = NIN'(merge_lanes(32'(irq_en_q), wdata, wmask));
      end else if (waddr == AW'(OFF_RISE_EN)) begin
        rise_en_d = NIN'(merge_lanes(32'(rise_en_q), wdata, wmask));
      end else if (waddr == AW'(OFF_FALL_EN)) begin
        fall_en_d = NIN'(merge_lanes(32'(fall_en_q), wdata, wmask));
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      if      (waddr == AW'(OFF_DFILT))    rdata = 32'(dfilt_q);
      else if (waddr == AW'(OFF_REFDIV))   rdata = 32'(refdiv_q);
      else if (waddr == AW'(OFF_IN))       rdata = 32'(filt);
      else if (waddr == AW'(OFF_OUT))      rdata = 32'(out_q);
      else if (waddr == AW'(OFF_IRQ_EN))   rdata = 32'(irq_en_q);
      else if (waddr == AW'(OFF_RISE_EN))  rdata = 32'(rise_en_q);
      else if (waddr == AW'(OFF_FALL_EN))  rdata = 32'(fall_en_q);
      else if (waddr == AW'(OFF_IRQ_STAT)) rdata = 32'(stat_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dfilt_q   <= '0;
      refdiv_q  <= '0;
      presc_q   <= '0;
      out_q     <= '0;
      irq_en_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      filt_d_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      dfilt_q   <= dfilt_d;
      refdiv_q  <= refdiv_d;
      presc_q   <= presc_d;
      out_q     <= out_d;
      irq_en_q  <= irq_en_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      filt_d_q  <= filt;
      irq_q     <= irq_d;
    end
  end

  assign gpio_pin_out = out_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb/tb_gpio_irq_ctrl.sv - directed bench for gpio_irq_ctrl with a cycle-level reference model
module tb_gpio_irq_ctrl;
  localparam int NIN = 13, NOUT = 8, AW = 14;

  logic            clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic [3:0]      we = '0;
  logic [31:0]     wdata = '0, rdata;
  logic [NIN-1:0]  pins = '0;
  logic [NOUT-1:0] pout;
  logic            irq;
  int              total = 0, bad = 0;

  always #5 clk = ~clk;

  gpio_irq_ctrl #(.NIN(NIN), .NOUT(NOUT), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata), .gpio_pin_in(pins), .gpio_pin_out(pout), .irq(irq)
  );

  // Reference state: register images, pin history, filtered value, run lengths.
  logic [7:0]      m_dfilt;
  logic [15:0]     m_refdiv;
  logic [NOUT-1:0] m_out;
  logic [NIN-1:0]  m_ien, m_ren, m_fen, m_stat, m_filt, m_filt_prev, m_h1, m_h2;
  logic            m_irq;
  int              m_since;
  int              m_run[NIN];

  function automatic logic [31:0] lanes(input logic [3:0] w);
    return {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] d, input logic [3:0] w);
    return (old & ~lanes(w)) | (d & lanes(w));
  endfunction

  task automatic model_reset();
    m_dfilt = '0; m_refdiv = '0; m_out = '0; m_ien = '0; m_ren = '0; m_fen = '0;
    m_stat = '0; m_filt = '0; m_filt_prev = '0; m_h1 = '0; m_h2 = '0; m_irq = 1'b0;
    m_since = 0;
    foreach (m_run[i]) m_run[i] = 0;
  endtask

  task automatic model_step();
    logic          wr_en = sel && (we != 4'b0000);
    logic [AW-1:0] a = {addr[AW-1:2], 2'b00};
    logic [31:0]   wm = wdata & lanes(we);
    logic          tick = ((m_since % (int'(m_refdiv) + 1)) == int'(m_refdiv));
    logic [NIN-1:0] nf = m_filt;
    logic [NIN-1:0] setb = (m_filt & ~m_filt_prev & m_ren) | (~m_filt & m_filt_prev & m_fen);
    logic [NIN-1:0] clr = (wr_en && a == 14'h040) ? NIN'(wm) : '0;
    m_irq = |(m_stat & m_ien);
    if (m_dfilt == 8'd0) begin
      nf = m_h2;
      foreach (m_run[i]) m_run[i] = 0;
    end else if (tick) begin
      for (int i = 0; i < NIN; i++) begin
        if (m_h2[i] != m_filt[i]) begin
          m_run[i]++;
          if (m_run[i] >= int'(m_dfilt)) begin
            nf[i] = m_h2[i];
            m_run[i] = 0;
          end
        end else m_run[i] = 0;
      end
    end
    m_stat = (m_stat & ~clr) | setb;
    m_filt_prev = m_filt;
    m_filt = nf;
    m_h2 = m_h1;
    m_h1 = pins;
    m_since++;
    if (wr_en) begin
      case (a)
        14'h000: m_dfilt  = 8'(mrg(32'(m_dfilt), wdata, we));
        14'h004: begin m_refdiv = 16'(mrg(32'(m_refdiv), wdata, we)); m_since = 0; end
        14'h020: m_out = NOUT'(mrg(32'(m_out), wdata, we));
        14'h024: m_out = m_out | NOUT'(wm);
        14'h028: m_out = m_out & ~NOUT'(wm);
        14'h030: m_ien = NIN'(mrg(32'(m_ien), wdata, we));
        14'h034: m_ren = NIN'(mrg(32'(m_ren), wdata, we));
        14'h038: m_fen = NIN'(mrg(32'(m_fen), wdata, we));
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [AW-1:0] a);
    case ({a[AW-1:2], 2'b00})
      14'h000: return 32'(m_dfilt);
      14'h004: return 32'(m_refdiv);
      14'h010: return 32'(m_filt);
      14'h020: return 32'(m_out);
      14'h030: return 32'(m_ien);
      14'h034: return 32'(m_ren);
      14'h038: return 32'(m_fen);
      14'h040: return 32'(m_stat);
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #3;
      chk("pin_out", 32'(pout), 32'(m_out));
      chk("irq", 32'(irq), 32'(m_irq));
      if (!sel) chk("rdata_idle", rdata, 32'h0);
    end
  end

  task automatic wr_reg(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] w);
    @(negedge clk);
    sel = 1'b1; addr = a; wdata = d; we = w;
    @(posedge clk);
    #1;
    sel = 1'b0; we = '0;
  endtask

  task automatic rd_lit(input string n, input logic [AW-1:0] a, input logic [31:0] exp);
    @(negedge clk);
    sel = 1'b1; addr = a; we = '0;
    #1;
    chk(n, rdata, exp);
    sel = 1'b0;
  endtask

  task automatic rd_mdl(input string n, input logic [AW-1:0] a);
    @(negedge clk);
    sel = 1'b1; addr = a; we = '0;
    #1;
    chk(n, rdata, m_rd(a));
    sel = 1'b0;
  endtask

  task automatic set_pins(input logic [NIN-1:0] v);
    @(negedge clk);
    pins = v;
  endtask

  logic [NIN-1:0] byp_vec[3] = '{13'h1FFF, 13'h1555, 13'h0AAA};

  initial begin
    logic [NIN-1:0] prev;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    rd_lit("rst_dfilt", 14'h000, 32'h0);
    rd_lit("rst_refdiv", 14'h004, 32'h0);
    rd_lit("rst_in", 14'h010, 32'h0);
    rd_lit("rst_out", 14'h020, 32'h0);
    rd_lit("rst_irq_en", 14'h030, 32'h0);
    rd_lit("rst_stat", 14'h040, 32'h0);
    #2 chk("rst_sel0_rdata", rdata, 32'h0);

    wr_reg(14'h020, 32'hAAAAAAAA, 4'b0001);
    chk("out_write_pins", 32'(pout), 32'hAA);
    rd_lit("out_lane0", 14'h020, 32'h000000AA);
    wr_reg(14'h024, 32'h00000005, 4'b0001);
    rd_lit("out_set", 14'h020, 32'h000000AF);
    wr_reg(14'h028, 32'h0000000A, 4'b0001);
    rd_lit("out_clr", 14'h020, 32'h000000A5);
    wr_reg(14'h020, 32'h000000FF, 4'b0000);
    rd_lit("out_we0", 14'h020, 32'h000000A5);
    wr_reg(14'h024, 32'h000000FF, 4'b0010);
    chk("set_lane_off_pins", 32'(pout), 32'hA5);
    wr_reg(14'h004, 32'h12345678, 4'b0010);
    rd_lit("refdiv_lane1", 14'h004, 32'h00005600);
    wr_reg(14'h000, 32'hFFFFFF04, 4'b1111);
    rd_lit("dfilt_width", 14'h000, 32'h00000004);
    wr_reg(14'h000, 32'h0, 4'b1111);
    rd_lit("unmapped", 14'h100, 32'h0);
    rd_lit("out_set_reads0", 14'h024, 32'h0);

    prev = '0;
    foreach (byp_vec[k]) begin
      set_pins(byp_vec[k]);
      @(negedge clk);
      rd_lit("byp_2clk_old", 14'h010, 32'(prev));
      rd_lit("byp_3clk_new", 14'h010, 32'(byp_vec[k]));
      prev = byp_vec[k];
    end

    wr_reg(14'h034, 32'h1, 4'b1111);
    wr_reg(14'h030, 32'h1, 4'b1111);
    set_pins(13'h0AAB);
    repeat (5) @(negedge clk);
    rd_lit("rise_stat", 14'h040, 32'h1);
    chk("rise_irq", 32'(irq), 32'h1);
    wr_reg(14'h040, 32'h1, 4'b0001);
    chk("w1c_irq_hold", 32'(irq), 32'h1);
    @(posedge clk);
    #1 chk("w1c_irq_drop", 32'(irq), 32'h0);
    rd_lit("w1c_stat", 14'h040, 32'h0);

    set_pins(13'h0AAA);
    repeat (4) @(negedge clk);
    set_pins(13'h0AAB);
    repeat (2) @(negedge clk);
    wr_reg(14'h040, 32'h1, 4'b0001);
    rd_lit("set_wins_stat", 14'h040, 32'h1);
    @(posedge clk);
    #1 chk("set_wins_irq", 32'(irq), 32'h1);

    wr_reg(14'h038, 32'h2, 4'b1111);
    set_pins(13'h0AA9);
    repeat (5) @(negedge clk);
    rd_lit("fall_stat", 14'h040, 32'h3);

    set_pins(13'h0AA8);
    repeat (4) @(negedge clk);
    wr_reg(14'h004, 32'h1, 4'b1111);
    wr_reg(14'h000, 32'h4, 4'b1111);
    set_pins(13'h0AA9);
    repeat (5) @(negedge clk);
    set_pins(13'h0AA8);
    for (int i = 0; i < 12; i++) rd_mdl("glitch_in_model", 14'h010);
    rd_lit("glitch_rejected", 14'h010, 32'h0AA8);

    set_pins(13'h0AA9);
    for (int i = 0; i < 14; i++) begin
      if (i < 8) rd_lit("filt_not_yet", 14'h010, 32'h0AA8);
      else if (i == 8) rd_mdl("filt_edge_model", 14'h010);
      else rd_lit("filt_passed", 14'h010, 32'h0AA9);
    end

    set_pins(13'h0AA8);
    repeat (4) @(negedge clk);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    chk("pre_rst_pins", 32'(pout), 32'hA5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_irq", 32'(irq), 32'h0);
    chk("async_rst_pins", 32'(pout), 32'h0);
    rd_lit("rst_mid_dfilt", 14'h000, 32'h0);
    rd_lit("rst_mid_refdiv", 14'h004, 32'h0);
    rd_lit("rst_mid_in", 14'h010, 32'h0);
    rd_lit("rst_mid_ien", 14'h030, 32'h0);
    rd_lit("rst_mid_stat", 14'h040, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) rd_mdl("post_rst_in", 14'h010);
    rd_lit("post_rst_in_lit", 14'h010, 32'h0AA8);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_irq_ctrl.md
# gpio_irq_ctrl

Parametrised memory-mapped GPIO controller: the next generation of the peripheral GPIO block, with configurable input and output widths, a per-pin digital glitch filter paced by a programmable sample clock, atomic set/clear of outputs, and edge-triggered interrupts with sticky write-1-to-clear status. It sits on the peripheral memory bus (select / address / byte-enable / write data / read data) beside the other peripheral blocks and drives one level interrupt to the interrupt controller.

## Interface
- NIN, 13: number of input pins (1..32)
- NOUT, 8: number of output pins (1..32)
- AW, 14: bus address width
- clk  in  1  global clock
- rst_n  in  1  global reset, asynchronous, active-low
- sel  in  1  block select
- addr  in  AW  byte address; bits [1:0] ignored
- we  in  4  byte write enables, we[i] covers wdata[8i+7:8i]
- wdata  in  32  write data
- rdata  out  32  read data, combinational
- gpio_pin_in  in  NIN  asynchronous input pins
- gpio_pin_out  out  NOUT  output pins, registered
- irq  out  1  interrupt request, level, registered

## Operation
- Register map (unmapped bits read 0, writes to them ignored):
  - 0x000 DFILT [7:0]: filter sample count; 0 = bypass
  - 0x004 REFDIV [15:0]: sample tick every REFDIV+1 clocks
  - 0x010 IN [NIN-1:0]: filtered input, read-only
  - 0x020 OUT [NOUT-1:0]: output data, read/write
  - 0x024 OUT_SET: write 1 sets OUT bits; reads 0
  - 0x028 OUT_CLR: write 1 clears OUT bits; reads 0
  - 0x030 IRQ_EN [NIN-1:0]
  - 0x034 RISE_EN [NIN-1:0]: rising edge sets status
  - 0x038 FALL_EN [NIN-1:0]: falling edge sets status
  - 0x040 IRQ_STAT [NIN-1:0]: sticky, write-1-to-clear
- Write: on posedge clk when sel=1, each byte lane with we[i]=1 is updated; lanes with we[i]=0 keep value. Any we pattern is legal.
- Read: rdata = selected register when sel=1; rdata = 0 when sel=0 or address unmapped.
- Input path per pin: 2-flop synchroniser -> filter -> filt register (IN).
- Prescaler: counter 0..REFDIV; tick when count == REFDIV, then count returns to 0. Any write to REFDIV clears count.
- Filter per pin (8-bit counter): DFILT=0 -> filt <= sync every clock, counter held 0. DFILT=N>0 -> on tick: sync==filt clears counter; sync!=filt increments counter, and when counter+1 >= N filt <= sync and counter clears. Between ticks filter state holds. A change therefore needs N consecutive differing ticks.
- Edge detect on filt: rise = filt & ~filt_d, fall = ~filt & filt_d. stat |= (rise & RISE_EN) | (fall & FALL_EN).
- IRQ_STAT W1C and a new edge on the same bit in the same cycle: set wins.
- irq <= |(IRQ_STAT & IRQ_EN), evaluated every clock.
- OUT_SET and OUT_CLR act only on lanes with we set; OUT write has priority over SET/CLR (separate addresses, never simultaneous).

## Timing
- Reset: every register, filt, filt_d, synchronisers, prescaler and counters 0; gpio_pin_out=0; irq=0; rdata=0 while sel=0. Reset is immediate mid-operation.
- Pins held high through reset produce a rising edge after release; status may set but irq stays 0 because IRQ_EN resets to 0.
- Write-to-output latency: gpio_pin_out changes at the write clock edge.
- Bypass input latency: pin change visible in IN after 3 clock edges (2 sync + filt).
- Edge to irq: stat set 1 edge after filt changes, irq 1 edge after stat.
- W1C of last enabled status bit: irq deasserts 1 edge after the clearing write.

## Structure
- Package gpio_irq_pkg: register offset constants, DFILT/REFDIV widths.
- Sub-module gpio_dfilter: one pin's synchroniser, counter and filt flop; instantiated NIN times by generate, sharing the tick and DFILT.
- Top holds bus decode, registers, prescaler, edge detect, status and irq.

## Test plan
- Reset defaults: read 0x000, 0x004, 0x010, 0x020, 0x030, 0x040 -> all 0x00000000; sel=0 -> rdata 0.
- Byte lanes, NOUT=8: write 0xAAAAAAAA we=0001 to 0x020 -> reads 0x000000AA, pins 0xAA; OUT_SET 0x05 -> 0xAF; OUT_CLR 0x0A -> 0xA5; we=0000 write -> unchanged.
- Bypass input: DFILT=0, pins 0x1FFF then 0x1555 then 0x0AAA -> IN matches 3 clocks after each change.
- Filter: DFILT=4, REFDIV=1; 3-tick glitch on pin 0 -> IN unchanged; 4-tick stable high -> IN[0]=1 after 8 clocks plus sync.
- Interrupt: RISE_EN=0x1, IRQ_EN=0x1, pin0 0->1 -> IRQ_STAT=0x1, irq=1; W1C 0x1 -> irq=0; W1C coinciding with new edge -> status stays 1.
- Async reset asserted mid-filter count with irq high -> irq, pins, all registers 0 immediately.
